// File: rtl/mux_nx1_pkg.sv
// Shared types and constants for the registered N:1 selector.
package mux_nx1_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
  localparam logic OUT_DATA_RST = 1'b0;
endpackage

// File: rtl/mux_nx1_reg_rr_pick.sv
// Round-robin picker: first valid channel strictly above ptr, wrapping to 0.
module rr_pick
  import mux_nx1_pkg::*;
#(
  parameter int NUM_IN = 16,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] in_valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              any
);
  logic             hi_any, lo_any;
  logic [SEL_W-1:0] hi_idx, lo_idx;

  // Descending scan so the lowest index in each half wins; ptr itself sits in
  // the low half, making it the last candidate after a full wrap.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        if (SEL_W'(k) > ptr) begin
          hi_any = 1'b1;
          hi_idx = SEL_W'(k);
        end else begin
          lo_any = 1'b1;
          lo_idx = SEL_W'(k);
        end
      end
    end
  end

  assign any   = hi_any | lo_any;
  assign grant = hi_any ? hi_idx : lo_idx;
endmodule

// File: rtl/mux_nx1_reg.sv
// Registered N:1 selector with valid/ready on both sides.
// Define MUX_NX1_RR_EN to build in round-robin auto-select (rr_mode, ptr).
module mux_nx1_reg
  import mux_nx1_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  input  logic                    rr_mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int NPAD = 1 << SEL_W;

  state_e           state;
  logic             space, use_rr, sel_oor, acc_fix, acc_rr, accept, pick_oor;
  logic [NPAD-1:0]  vld_pad;
  logic [SEL_W-1:0] pick_idx;
  logic [WIDTH-1:0] pick_data;

`ifdef MUX_NX1_RR_EN
  logic [SEL_W-1:0] ptr, rr_grant;
  logic             rr_any;

  rr_pick #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_pick (
    .in_valid (in_valid),
    .ptr      (ptr),
    .grant    (rr_grant),
    .any      (rr_any)
  );

  assign use_rr = rr_mode;
  assign acc_rr = space && rr_any;
`else
  logic unused_rr_mode;
  assign unused_rr_mode = rr_mode;
  assign use_rr = 1'b0;
  assign acc_rr = 1'b0;
`endif

  always_comb begin
    vld_pad = '0;
    vld_pad[NUM_IN-1:0] = in_valid;
  end

  assign space    = (state == EMPTY) || out_ready;
  assign sel_oor  = {1'b0, sel} >= (SEL_W + 1)'(NUM_IN);
  assign acc_fix  = sel_valid && space && (sel_oor || vld_pad[sel]);
  assign accept   = !rst && (use_rr ? acc_rr : acc_fix);
  assign sel_ready = !rst && !use_rr && acc_fix;
  assign pick_oor = !use_rr && sel_oor;

`ifdef MUX_NX1_RR_EN
  assign pick_idx = use_rr ? rr_grant : sel;
`else
  assign pick_idx = sel;
`endif

  // Out-of-range indices match no channel, so the word and the strobe stay 0.
  always_comb begin
    pick_data = '0;
    in_ready  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (pick_idx == SEL_W'(k)) begin
        pick_data   = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = accept && !pick_oor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= {WIDTH{OUT_DATA_RST}};
      out_src   <= '0;
      out_err   <= 1'b0;
`ifdef MUX_NX1_RR_EN
      ptr       <= SEL_W'(NUM_IN - 1);
`endif
    end else if (accept) begin
      state     <= FULL;
      out_valid <= 1'b1;
      out_data  <= pick_oor ? {WIDTH{OUT_DATA_RST}} : pick_data;
      out_src   <= pick_idx;
      out_err   <= pick_oor;
`ifdef MUX_NX1_RR_EN
      if (use_rr) ptr <= rr_grant;
`endif
    end else if (out_ready) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
    end
  end
endmodule
